// File: rtl/if_bp_fetch.sv
// rtl/if_bp_fetch.sv - fetch stage with saturating-counter BHT branch prediction and in-flight branch queue
// Optional build macro: GSHARE_EN (XOR global history into the BHT lookup index)
module if_bp_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_IDX  = 8,
    parameter int          CTR_W    = 2,
    parameter int          BQ_IDX   = 4,
    parameter int          GHR_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic [31:0] jp_pc,
    input  logic        jp_commit,
    input  logic        stall_ID,
    output logic        ins_flag_ID,
    output logic [31:0] ins_ID,
    output logic        jp_flag_ID,
    output logic [31:0] jp_pc_ID,
    input  logic        ins_flag,
    input  logic [31:0] ins,
    output logic [31:0] pc_out,
    output logic        bq_full
);

    localparam int BHT_N = 1 << BHT_IDX;
    localparam int BQ_N  = 1 << BQ_IDX;

    localparam logic [6:0]       OP_BRANCH = 7'b1100011;
    localparam logic [6:0]       OP_JAL    = 7'b1101111;
    localparam logic [CTR_W-1:0] CTR_INIT  = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO  = {CTR_W{1'b0}};
    localparam logic [BQ_IDX:0]  BQ_DEPTH  = (BQ_IDX+1)'(BQ_N);

    logic [31:0]        pc;
    logic [CTR_W-1:0]   bht [BHT_N];

    logic [BHT_IDX-1:0] bq_idx [BQ_N];
    logic               bq_dir [BQ_N];
    logic [BQ_IDX-1:0]  bq_head;
    logic [BQ_IDX-1:0]  bq_tail;
    logic [BQ_IDX:0]    bq_cnt;

`ifdef GSHARE_EN
    logic [GHR_W-1:0]   ghr;
    logic [GHR_W-1:0]   bq_ghr [BQ_N];
`endif

    logic               is_br;
    logic               is_jal;
    logic [31:0]        imm_b;
    logic [31:0]        imm_j;
    logic [31:0]        pc_seq;
    logic [31:0]        pc_tgt;
    logic [BHT_IDX-1:0] lookup_idx;
    logic               pred_taken;
    logic               accept;
    logic               do_push;
    logic               do_commit;
    logic [BHT_IDX-1:0] head_idx;
    logic               actual_taken;

    assign is_br  = (ins[6:0] == OP_BRANCH);
    assign is_jal = (ins[6:0] == OP_JAL);
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign pc_seq = pc + 32'd4;
    assign pc_tgt = pc + (is_jal ? imm_j : imm_b);

`ifdef GSHARE_EN
    assign lookup_idx = pc[BHT_IDX+1:2] ^ BHT_IDX'(ghr);
`else
    assign lookup_idx = pc[BHT_IDX+1:2];
`endif

    assign pred_taken  = bht[lookup_idx][CTR_W-1];
    assign bq_full     = (bq_cnt == BQ_DEPTH);
    assign ins_ID      = ins;
    // a branch that cannot be tracked is withheld from the decoder until a slot frees
    assign ins_flag_ID = ins_flag & ~(is_br & bq_full);
    assign accept      = ins_flag_ID & ~stall_ID;
    // a redirect discards this cycle's fetch, so nothing is pushed
    assign do_push     = accept & is_br & ~jp_wrong;
    assign do_commit   = jp_commit & (bq_cnt != '0);
    assign head_idx    = bq_idx[bq_head];
    // a mispredict flag on the committing branch means its prediction was wrong
    assign actual_taken = bq_dir[bq_head] ^ jp_wrong;

    // next fetch address and the alternate path handed to the decoder
    always_comb begin
        pc_out     = pc;
        jp_flag_ID = 1'b0;
        jp_pc_ID   = pc;
        if (accept) begin
            pc_out   = pc_seq;
            jp_pc_ID = pc_seq;
            if (is_jal || (is_br && pred_taken)) begin
                pc_out     = pc_tgt;
                jp_flag_ID = 1'b1;
            end else if (is_br) begin
                jp_pc_ID = pc_tgt;
            end
        end
    end

    // BHT training on commit; the lookup above still sees the old counter this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (rdy && do_commit) begin
            if (actual_taken) begin
                if (bht[head_idx] != CTR_MAX) begin
                    bht[head_idx] <= bht[head_idx] + 1'b1;
                end
            end else if (bht[head_idx] != CTR_ZERO) begin
                bht[head_idx] <= bht[head_idx] - 1'b1;
            end
        end
    end

    // branch queue payload; only the occupancy pointers need a reset
    always_ff @(posedge clk) begin
        if (!rst && rdy && do_push) begin
            bq_idx[bq_tail] <= lookup_idx;
            bq_dir[bq_tail] <= pred_taken;
`ifdef GSHARE_EN
            bq_ghr[bq_tail] <= ghr;
`endif
        end
    end

    // fetch PC, queue pointers and global history
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            bq_head <= '0;
            bq_tail <= '0;
            bq_cnt  <= '0;
`ifdef GSHARE_EN
            ghr     <= '0;
`endif
        end else if (rdy) begin
            if (jp_wrong) begin
                pc      <= jp_pc;
                bq_head <= '0;
                bq_tail <= '0;
                bq_cnt  <= '0;
`ifdef GSHARE_EN
                if (do_commit) begin
                    ghr <= {bq_ghr[bq_head][GHR_W-2:0], actual_taken};
                end
`endif
            end else begin
                if (accept) begin
                    pc <= pc_out;
                end
                if (do_commit) begin
                    bq_head <= bq_head + 1'b1;
                end
                if (do_push) begin
                    bq_tail <= bq_tail + 1'b1;
`ifdef GSHARE_EN
                    ghr     <= {ghr[GHR_W-2:0], pred_taken};
`endif
                end
                case ({do_push, do_commit})
                    2'b10:   bq_cnt <= bq_cnt + 1'b1;
                    2'b01:   bq_cnt <= bq_cnt - 1'b1;
                    default: bq_cnt <= bq_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_bp_fetch.sv
// tb/tb_if_bp_fetch.sv - scoreboard bench for if_bp_fetch against a behavioural fetch/BHT/queue model
module tb_if_bp_fetch;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] JALR = 32'h000080e7;
    localparam int          QDEP = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, jp_wrong, jp_commit, stall_ID, ins_flag;
    logic [31:0] jp_pc, ins;
    logic        ins_flag_ID, jp_flag_ID, bq_full;
    logic [31:0] ins_ID, jp_pc_ID, pc_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc_out;
        logic [31:0] jp_pc;
        logic        jp_flag;
        logic        ins_flag;
        logic [31:0] ins;
        logic        full;
    } exp_t;

    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    exp_t        sb[$];
    ent_t        m_q[$];
    int          m_bht[256];
    logic [31:0] m_pc;

    if_bp_fetch #(
        .RESET_PC(32'h0), .BHT_IDX(8), .CTR_W(2), .BQ_IDX(2), .GHR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .jp_pc(jp_pc),
        .jp_commit(jp_commit), .stall_ID(stall_ID), .ins_flag_ID(ins_flag_ID),
        .ins_ID(ins_ID), .jp_flag_ID(jp_flag_ID), .jp_pc_ID(jp_pc_ID),
        .ins_flag(ins_flag), .ins(ins), .pc_out(pc_out), .bq_full(bq_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @pc=%h: got %h expected %h", tag, m_pc, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    // one clock: drive, predict, compare outputs, advance model across the edge
    task automatic step(input bit rs, input bit rd, input bit fl, input logic [31:0] in,
                        input int imm, input bit st, input bit wr,
                        input logic [31:0] jpc, input bit cm);
        bit   isbr, isjal, pred, full, ifl, acc, act;
        int   idx;
        exp_t e, g;
        ent_t h;
        rst = rs; rdy = rd; ins_flag = fl; ins = in; stall_ID = st;
        jp_wrong = wr; jp_pc = jpc; jp_commit = cm;
        isbr  = (in[6:0] == 7'b1100011);
        isjal = (in[6:0] == 7'b1101111);
        idx   = int'(m_pc[9:2]);
        pred  = (m_bht[idx] >= 2);
        full  = (m_q.size() == QDEP);
        ifl   = fl && !(isbr && full);
        acc   = ifl && !st;
        e.pc_out = m_pc; e.jp_pc = m_pc; e.jp_flag = 1'b0;
        e.ins_flag = ifl; e.ins = in; e.full = full;
        if (acc) begin
            if (isjal || (isbr && pred)) begin
                e.pc_out = m_pc + 32'(imm); e.jp_pc = m_pc + 32'd4; e.jp_flag = 1'b1;
            end else if (isbr) begin
                e.pc_out = m_pc + 32'd4; e.jp_pc = m_pc + 32'(imm);
            end else begin
                e.pc_out = m_pc + 32'd4; e.jp_pc = m_pc + 32'd4;
            end
        end
        if (!rs) sb.push_back(e);
        #1;
        if (sb.size() != 0) begin
            g = sb.pop_front();
            check("pc_out", pc_out, g.pc_out);
            check("jp_pc_ID", jp_pc_ID, g.jp_pc);
            check("jp_flag_ID", 32'(jp_flag_ID), 32'(g.jp_flag));
            check("ins_flag_ID", 32'(ins_flag_ID), 32'(g.ins_flag));
            check("ins_ID", ins_ID, g.ins);
            check("bq_full", 32'(bq_full), 32'(g.full));
        end
        if (rs) begin
            m_pc = 32'h0;
            m_q.delete();
            foreach (m_bht[i]) m_bht[i] = 1;
        end else if (rd) begin
            if (cm && m_q.size() != 0) begin
                h = m_q.pop_front();
                act = h.pred ^ wr;
                if (act && m_bht[h.idx] < 3) m_bht[h.idx]++;
                if (!act && m_bht[h.idx] > 0) m_bht[h.idx]--;
            end
            if (wr) begin
                m_pc = jpc;
                m_q.delete();
            end else if (acc) begin
                m_pc = e.pc_out;
                if (isbr) m_q.push_back('{idx: idx, pred: pred});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] in, input int imm);
        step(0, 1, 1, in, imm, 0, 0, 32'h0, 0);
    endtask

    task automatic redirect(input logic [31:0] tgt, input bit cm);
        step(0, 1, 0, NOP, 0, 0, 1, tgt, cm);
    endtask

    task automatic commit_only(input bit wr, input logic [31:0] tgt);
        step(0, 1, 0, NOP, 0, 0, wr, tgt, 1);
    endtask

    initial begin
        int          sel, imm;
        bit          rs, rd, fl, st, wr, cm;
        logic [31:0] in, jpc;
        m_pc = 32'h0;
        foreach (m_bht[i]) m_bht[i] = 1;
        @(posedge clk);
        #1;
        step(1, 0, 1, NOP, 0, 0, 1, 32'h44, 1);
        step(1, 1, 0, NOP, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, NOP, 0, 0, 0, 32'h0, 0);

        repeat (3) go(NOP, 0);

        redirect(32'h10, 0);
        go(enc_b(32'h20), 32'h20);
        commit_only(1, 32'h30);
        redirect(32'h10, 0);
        go(enc_b(32'h20), 32'h20);

        commit_only(0, 32'h0);
        repeat (3) begin
            redirect(32'h10, 0);
            go(enc_b(32'h400), 32'h400);
            step(0, 1, 1, NOP, 0, 0, 0, 32'h0, 1);
        end
        redirect(32'h10, 0);
        go(enc_b(32'h400), 32'h400);
        commit_only(0, 32'h0);

        repeat (2) begin
            redirect(32'h200, 0);
            go(enc_b(32'h40), 32'h40);
            commit_only(0, 32'h0);
        end
        redirect(32'h200, 0);
        go(enc_b(32'h40), 32'h40);

        redirect(32'h100, 0);
        go(enc_j(-8), -8);

        redirect(32'h300, 0);
        repeat (4) go(enc_b(32'h40), 32'h40);
        step(0, 1, 1, enc_b(32'h40), 32'h40, 0, 0, 32'h0, 1);
        go(enc_b(32'h40), 32'h40);

        repeat (2) step(0, 1, 1, NOP, 0, 1, 0, 32'h0, 0);
        repeat (2) step(0, 0, 1, enc_b(32'h40), 32'h40, 0, 1, 32'h80, 1);
        go(NOP, 0);
        repeat (4) commit_only(0, 32'h0);
        commit_only(0, 32'h0);
        go(JALR, 0);

        repeat (400) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: begin in = NOP; imm = 0; end
                1: begin imm = (int'($urandom_range(0, 4095)) - 2048) * 2; in = enc_b(imm); end
                2: begin imm = (int'($urandom_range(0, 1023)) - 512) * 2; in = enc_j(imm); end
                default: begin in = JALR; imm = 0; end
            endcase
            rs  = ($urandom_range(0, 99) < 2);
            rd  = ($urandom_range(0, 99) < 90);
            fl  = ($urandom_range(0, 99) < 85);
            st  = ($urandom_range(0, 99) < 20);
            wr  = ($urandom_range(0, 99) < 10);
            cm  = ($urandom_range(0, 99) < 35);
            jpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            step(rs, rd, fl, in, imm, st, wr, jpc, cm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
